// File: rtl/mem_pkg.sv
// Shared types and geometry helpers for the main-memory block responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DROP
  } state_t;

  // Byte offset within one line; the index field sits directly above it.
  function automatic int offset_bits(input int word_size, input int block_size);
    return $clog2(block_size * word_size / 8);
  endfunction

  function automatic int index_bits(input int mem_lines);
    return $clog2(mem_lines);
  endfunction

  function automatic int line_w(input int word_size, input int block_size);
    return word_size * block_size;
  endfunction

endpackage

// File: rtl/mem_block_responder_if.sv
// Cache <-> main memory block request bus. Err exists only with MEM_RANGE_CHECK_EN.
interface mem_block_responder_if
  import mem_pkg::*;
#(
  parameter int Word_Size  = 32,
  parameter int Block_Size = 4
);
  localparam int LW = line_w(Word_Size, Block_Size);

  logic                 OE;
  logic                 WE;
  logic [Word_Size-1:0] Addr;
  logic [LW-1:0]        Data_Wr;
  logic [LW-1:0]        Data_Rd;
  logic                 Ready_Mem;
  logic                 Busy;
`ifdef MEM_RANGE_CHECK_EN
  logic                 Err;
`endif

  modport master (
    output OE, WE, Addr, Data_Wr,
`ifdef MEM_RANGE_CHECK_EN
    input  Err,
`endif
    input  Data_Rd, Ready_Mem, Busy
  );

  modport slave (
    input  OE, WE, Addr, Data_Wr,
`ifdef MEM_RANGE_CHECK_EN
    output Err,
`endif
    output Data_Rd, Ready_Mem, Busy
  );

endinterface

// File: rtl/mem_block_responder_line_array.sv
// Line storage: one synchronous write port and one registered (1-cycle) read port.
module mem_line_array #(
  parameter int Depth = 1024,
  parameter int Width = 128,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_block_responder.sv
// Main-memory block responder: fixed-latency line read/write with a four-phase handshake.
// Optional macro MEM_RANGE_CHECK_EN adds Err for addresses beyond the array.
module mem_block_responder
  import mem_pkg::*;
#(
  parameter int Word_Size  = 32,
  parameter int Block_Size = 4,
  parameter int Mem_Lines  = 1024,
  parameter int Latency    = 5
) (
  input logic                  clk,
  input logic                  reset,
  mem_block_responder_if.slave bus
);

  localparam int LW = line_w(Word_Size, Block_Size);
  localparam int OB = offset_bits(Word_Size, Block_Size);
  localparam int IB = index_bits(Mem_Lines);
  localparam int CW = (Latency > 1) ? $clog2(Latency) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IB-1:0] cap_idx;
  logic [LW-1:0] cap_data;
  logic          cap_wr;
  logic [LW-1:0] rd_hold;
  logic [LW-1:0] arr_rdata;
  logic [LW-1:0] rd_line;
  logic          accept;
  logic          arr_re;
  logic          arr_we;
  logic          ready;
  logic          range_err;

`ifdef MEM_RANGE_CHECK_EN
  logic cap_hi;

  always_ff @(posedge clk) begin
    if (accept) cap_hi <= (bus.Addr >> (OB + IB)) != '0;
  end

  assign range_err = cap_hi;
  assign bus.Err   = ready & range_err;
`else
  assign range_err = 1'b0;
`endif

  assign accept = (state == IDLE) && (bus.OE || bus.WE);

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_idx  <= bus.Addr[OB +: IB];
      cap_data <= bus.Data_Wr;
      cap_wr   <= bus.WE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_hold <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == RESP && !cap_wr) rd_hold <= rd_line;
    end
  end

  // The array read is launched on the final WAIT edge so its registered output lands in RESP.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    arr_re   = 1'b0;
    arr_we   = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = CW'(Latency - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          arr_re   = !cap_wr;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        ready    = 1'b1;
        arr_we   = cap_wr && !range_err && !reset;
        state_nx = DROP;
      end
      DROP: begin
        if (!bus.OE && !bus.WE) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  mem_line_array #(
    .Depth (Mem_Lines),
    .Width (LW),
    .AW    (IB)
  ) u_lines (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cap_idx),
    .wdata (cap_data),
    .re    (arr_re),
    .raddr (cap_idx),
    .rdata (arr_rdata)
  );

  assign rd_line       = range_err ? '0 : arr_rdata;
  assign bus.Data_Rd   = (state == RESP && !cap_wr) ? rd_line : rd_hold;
  assign bus.Ready_Mem = ready;
  assign bus.Busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_block_responder.sv
// Randomized self-checking bench for mem_block_responder against a line-array reference model.
module tb_mem_block_responder;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_block_responder_if #(.Word_Size(32), .Block_Size(4)) bus ();

  mem_block_responder #(
    .Word_Size  (32),
    .Block_Size (4),
    .Mem_Lines  (1024),
    .Latency    (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] model_mem [int];
  logic [127:0] last_rd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % 1024);
  endfunction

  function automatic bit err_of(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return (a >> 14) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full handshake; `hold` extra cycles keep the request asserted after Ready_Mem.
  task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [127:0] d, input int hold);
    int n;
    int idx;
    bit er;
    logic [127:0] exp;
    @(negedge clk);
    chk("idle_before_req", bus.Busy, 1'b0);
    bus.OE = rd; bus.WE = wr; bus.Addr = a; bus.Data_Wr = d;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_accept", bus.Busy, 1'b1);
    bus.Addr = $urandom;
    bus.Data_Wr = rnd_line();
    n = 0;
    while (bus.Ready_Mem !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(LAT));
    idx = idx_of(a);
    er  = err_of(a);
`ifdef MEM_RANGE_CHECK_EN
    chk("err", bus.Err, er);
`endif
    if (wr) begin
      chk("rd_hold_on_write", bus.Data_Rd, last_rd);
      if (!er) model_mem[idx] = d;
    end else begin
      exp = er ? 128'h0 : model_mem[idx];
      chk("read_data", bus.Data_Rd, exp);
      last_rd = exp;
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("no_second_ready", bus.Ready_Mem, 1'b0);
    end
    bus.OE = 1'b0; bus.WE = 1'b0;
    n = 0;
    while (bus.Busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("release_busy", bus.Busy, 1'b0);
    chk("rd_hold_after", bus.Data_Rd, last_rd);
  endtask

  initial begin
    logic [127:0] pat;
    logic [31:0] a;
    int n;
    bit seen;

    reset = 1'b1;
    bus.OE = 1'b0; bus.WE = 1'b0; bus.Addr = '0; bus.Data_Wr = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.Ready_Mem !== 1'b0 || bus.Busy !== 1'b0) seen = 1'b1;
    end
    chk("idle_no_activity", seen, 1'b0);
    chk("reset_data_rd", bus.Data_Rd, 128'h0);

    pat = {4{32'hA5A5A5A5}};
    do_op(1'b1, 1'b0, 32'h40, pat, 0);
    do_op(1'b0, 1'b1, 32'h44, '0, 0);
    chk("read_offset_ignored", last_rd, pat);
    do_op(1'b0, 1'b1, 32'h44, '0, 3);
    do_op(1'b0, 1'b1, 32'h48, '0, 0);

    do_op(1'b1, 1'b1, 32'h80, 128'h1234, 0);
    do_op(1'b0, 1'b1, 32'h80, '0, 0);
    chk("write_wins", last_rd, 128'h1234);

    do_op(1'b1, 1'b0, 32'hC0, 128'hC0FFEE, 0);
    @(negedge clk);
    bus.WE = 1'b1; bus.Addr = 32'hC0; bus.Data_Wr = 128'hDEAD;
    @(posedge clk);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.Ready_Mem === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    bus.WE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.Busy, 1'b0);
    chk("abort_data_rd", bus.Data_Rd, 128'h0);
    last_rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.Ready_Mem === 1'b1) seen = 1'b1;
    end
    chk("abort_no_ready", seen, 1'b0);
    do_op(1'b0, 1'b1, 32'hC0, '0, 0);
    chk("abort_no_commit", last_rd, 128'hC0FFEE);

    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 1'b0, 32'(i * 16), rnd_line(), 0);
    end

    do_op(1'b0, 1'b1, 32'h4000, '0, 0);
`ifdef MEM_RANGE_CHECK_EN
    chk("range_read_zero", last_rd, 128'h0);
`else
    chk("alias_line0", last_rd, model_mem[0]);
`endif

    for (int i = 0; i < 40; i++) begin
      a = {($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'h0,
           10'($urandom_range(0, 15)), 4'($urandom)};
      n = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        do_op(1'b1, ($urandom_range(0, 3) == 0), a, rnd_line(), n);
      else
        do_op(1'b0, 1'b1, a, '0, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hung expected finish");
    $fatal(1);
  end

endmodule
